// File: rtl/bch15_7_5_encode.sv
// Systematic BCH(15,7,5) serial encoder.
// A 7-bit message is captured in parallel. It is sent MSB first, and 8 parity
// bits generated by an LFSR for g(x) = x^8 + x^7 + x^6 + x^4 + 1 follow it.
// A short HOLD tail keeps the channel owned after the last parity bit, and
// done pulses in the first cycle of that tail.
module bch15_7_5_encode #(
    parameter int HOLD = 2          // tail cycles after last parity bit, 1..16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [6:0]  inw,
    input  logic        ostall,
    output logic        bsy,
    output logic        obit,
    output logic        ovalid,
    output logic        done,
    output logic [14:0] cw
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MSG  = 2'd1,
        S_PAR  = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    localparam logic [3:0] MSG_LAST  = 4'd6;
    localparam logic [3:0] PAR_LAST  = 4'd7;
    localparam logic [3:0] HOLD_LAST = 4'(HOLD - 1);
    localparam logic [7:0] G_TAPS    = 8'hD1;   // g(x) without the x^8 term

    state_t      state;
    logic [6:0]  msg;
    logic [7:0]  lfsr;
    logic [3:0]  cnt;

    // One step of the division LFSR. In the parity phase the bit being sent
    // is lfsr[7] itself, so the feedback cancels and the register simply
    // shifts out the remainder. This lets both phases share one step.
    function automatic logic [7:0] lfsr_step(input logic [7:0] cur, input logic din);
        logic fb;
        fb = din ^ cur[7];
        return {cur[6:0], 1'b0} ^ (fb ? G_TAPS : 8'h00);
    endfunction

    // Serial outputs decode directly from registered state, so they stay
    // steady through a stall without any extra holding logic.
    always_comb begin
        bsy    = 1'b0;
        ovalid = 1'b0;
        obit   = 1'b0;
        done   = 1'b0;
        case (state)
            S_MSG: begin
                bsy    = 1'b1;
                ovalid = 1'b1;
                obit   = msg[6];
            end
            S_PAR: begin
                bsy    = 1'b1;
                ovalid = 1'b1;
                obit   = lfsr[7];
            end
            S_HOLD: begin
                bsy    = 1'b1;
                done   = (cnt == 4'd0);
            end
            default: ;
        endcase
    end

    // Encoder FSM: capture the message, shift the message bits, shift the
    // parity bits, then hold the channel for the tail before going idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            msg   <= '0;
            lfsr  <= '0;
            cnt   <= '0;
            cw    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        msg   <= inw;
                        lfsr  <= '0;
                        cnt   <= '0;
                        state <= S_MSG;
                    end
                end
                S_MSG: begin
                    if (!ostall) begin
                        lfsr <= lfsr_step(lfsr, obit);
                        msg  <= {msg[5:0], 1'b0};
                        cw   <= {cw[13:0], obit};
                        if (cnt == MSG_LAST) begin
                            cnt   <= '0;
                            state <= S_PAR;
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end
                end
                S_PAR: begin
                    if (!ostall) begin
                        lfsr <= lfsr_step(lfsr, obit);
                        cw   <= {cw[13:0], obit};
                        if (cnt == PAR_LAST) begin
                            cnt   <= '0;
                            state <= S_HOLD;
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end
                end
                S_HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        cnt   <= '0;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bch15_7_5_encode.sv
// Testbench for bch15_7_5_encode: a stimulus process issues words, with stalls,
// and a scoreboard monitor compares each finished codeword against a
// polynomial-division reference model.
module tb_bch15_7_5_encode;

    localparam int HOLD = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [6:0]  inw = '0;
    logic        ostall = 1'b0;
    logic        bsy, obit, ovalid, done;
    logic [14:0] cw;

    bch15_7_5_encode #(.HOLD(HOLD)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .inw    (inw),
        .ostall (ostall),
        .bsy    (bsy),
        .obit   (obit),
        .ovalid (ovalid),
        .done   (done),
        .cw     (cw)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int errors  = 0;

    typedef struct {
        logic [14:0] cw;
        int          dcyc;
    } exp_t;
    exp_t q[$];

    int stl[15];

    // Reference: codeword = m(x)*x^8 + (m(x)*x^8 mod g(x)), by long division.
    function automatic logic [14:0] ref_cw(input logic [6:0] m);
        int r;
        int shifted;
        shifted = int'(m) << 8;
        r = shifted;
        for (int i = 14; i >= 8; i--)
            if (((r >> i) & 1) == 1) r = r ^ (32'h1D1 << (i - 8));
        return 15'(shifted | (r & 32'hFF));
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stalls();
        for (int b = 0; b < 15; b++) stl[b] = 0;
    endtask

    // Issue one word. The caller is in an idle cycle, just after a posedge.
    task automatic run_word(input logic [6:0] w, input bit keep_start);
        exp_t e;
        int ns;
        ns = 0;
        for (int b = 0; b < 15; b++) ns += stl[b];
        e.cw   = ref_cw(w);
        e.dcyc = cyc + 16 + ns;
        q.push_back(e);
        start = 1'b1;
        inw   = w;
        tick();
        start = keep_start;
        inw   = 7'($urandom);
        for (int b = 0; b < 15; b++) begin
            repeat (stl[b]) begin
                ostall = 1'b1;
                tick();
            end
            ostall = 1'b0;
            tick();
        end
        for (int h = 0; h < HOLD; h++) begin
            ostall = 1'($urandom);
            tick();
        end
        ostall = 1'b0;
    endtask

    // Scoreboard monitor
    logic [14:0] sh = '0;
    int nb = 0;
    bit hchk = 1'b0;
    int ht = 0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            nb   = 0;
            hchk = 1'b0;
        end else begin
            if (ovalid && !ostall) begin
                sh = {sh[13:0], obit};
                nb++;
            end
            if (!bsy) begin
                chk("idle_ovalid", 32'(ovalid), 0);
                chk("idle_done", 32'(done), 0);
            end
            if (done) begin
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done: got done=1 expected no pending word at cycle %0d", cyc);
                end else begin
                    e = q.pop_front();
                    vectors++;
                    chk("serial_stream", 32'(sh), 32'(e.cw));
                    chk("bit_count", nb, 15);
                    chk("cw", 32'(cw), 32'(e.cw));
                    chk("done_cycle", cyc, e.dcyc);
                end
                nb   = 0;
                hchk = 1'b1;
                ht   = cyc;
            end
            if (hchk) begin
                if (cyc < ht + HOLD) begin
                    chk("hold_bsy", 32'(bsy), 1);
                    chk("hold_ovalid", 32'(ovalid), 0);
                    chk("hold_done", 32'(done), 32'(cyc == ht));
                end else begin
                    chk("bsy_fall", 32'(bsy), 0);
                    hchk = 1'b0;
                end
            end
        end
    end

    initial begin
        bit keep;
        // Reset, then idle
        rst_n = 1'b0;
        repeat (3) begin
            tick();
            chk("rst_bsy", 32'(bsy), 0);
            chk("rst_ovalid", 32'(ovalid), 0);
            chk("rst_cw", 32'(cw), 0);
        end
        rst_n = 1'b1;
        repeat (20) begin
            tick();
            chk("idle_bsy", 32'(bsy), 0);
            chk("idle_cw", 32'(cw), 0);
        end

        // Directed words, no stall
        clear_stalls();
        run_word(7'h01, 1'b0);
        chk("cw_01", 32'(cw), 32'h01D1);
        run_word(7'h40, 1'b0);
        chk("cw_40", 32'(cw), 32'h40E8);
        run_word(7'h7F, 1'b0);
        chk("cw_7F", 32'(cw), 32'h7FFF);
        run_word(7'h00, 1'b0);
        chk("cw_00", 32'(cw), 32'h0000);

        // Stalls in the message and parity phases
        clear_stalls();
        stl[5]  = 3;
        stl[10] = 2;
        run_word(7'h40, 1'b0);
        chk("cw_40_stall", 32'(cw), 32'h40E8);

        // Back-to-back with start held high throughout
        clear_stalls();
        run_word(7'h01, 1'b1);
        run_word(7'h7F, 1'b0);
        chk("cw_b2b", 32'(cw), 32'h7FFF);

        // Reset between edges during parity bit 3
        tick();
        q.push_back('{cw: 15'h0, dcyc: 0});
        start = 1'b1;
        inw   = 7'h40;
        tick();
        start = 1'b0;
        repeat (10) tick();
        chk("pre_rst_ovalid", 32'(ovalid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_bsy", 32'(bsy), 0);
        chk("midrst_ovalid", 32'(ovalid), 0);
        chk("midrst_obit", 32'(obit), 0);
        chk("midrst_done", 32'(done), 0);
        chk("midrst_cw", 32'(cw), 0);
        q.delete();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        run_word(7'h01, 1'b0);
        chk("cw_after_rst", 32'(cw), 32'h01D1);

        // All 128 messages with random stalls and random held start
        for (int i = 0; i < 128; i++) begin
            for (int b = 0; b < 15; b++)
                stl[b] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            keep = (i != 127) && ($urandom_range(0, 1) == 1);
            run_word(7'(i), keep);
        end

        start = 1'b0;
        repeat (5) tick();
        chk("pending_words", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
